// File: rtl/dma_sched_pkg.sv
// rtl/dma_sched_pkg.sv - shared types and constants for the DMA job scheduler
package dma_sched_pkg;

  // Widths of the job record; they track the scheduler's default parameters.
  localparam int SCHED_NUM_REQ = 4;
  localparam int ID_W          = $clog2(SCHED_NUM_REQ);
  localparam int SCHED_ADDR_W  = 32;
  localparam int SCHED_BYTES_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GO,
    WAIT,
    ABORT,
    CMPL
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_ADDR_W-1:0]  src;
    logic [SCHED_ADDR_W-1:0]  dst;
    logic [SCHED_BYTES_W-1:0] bytes;
    logic                     rd_mode;
    logic                     wr_mode;
    logic [ID_W-1:0]          id;
  } sched_job_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - round-robin arbiter with one-hot grant and encoded index
module dma_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    sum   = '0;
    any_o = 1'b0;
    gnt_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (en_i && rot[k]) begin
        sum   = {1'b0, ptr_i} + (IDX_W+1)'(k);
        any_o = 1'b1;
      end
    end
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end
    idx_o = sum[IDX_W-1:0];
    if (any_o) begin
      gnt_o = NUM_REQ'(1) << idx_o;
    end
  end

endmodule

// File: rtl/dma_job_scheduler.sv
// rtl/dma_job_scheduler.sv - shares one DMA engine between requesters, one descriptor job at a time
module dma_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_BURST   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_i,
  input  logic [NUM_REQ*BYTES_WIDTH-1:0] req_bytes_i,
  input  logic [NUM_REQ-1:0]            req_rd_mode_i,
  input  logic [NUM_REQ-1:0]            req_wr_mode_i,
  output logic                          cmp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    cmp_id_o,
  output logic                          cmp_error_o,
  output logic                          dma_go_o,
  output logic                          dma_abort_o,
  output logic [7:0]                    dma_max_burst_o,
  output logic [ADDR_WIDTH-1:0]         desc_src_o,
  output logic [ADDR_WIDTH-1:0]         desc_dst_o,
  output logic [BYTES_WIDTH-1:0]        desc_bytes_o,
  output logic                          desc_rd_mode_o,
  output logic                          desc_wr_mode_o,
  output logic                          desc_en_o,
  input  logic                          dma_done_i,
  input  logic                          dma_error_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  import dma_sched_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  sched_state_e     state_q, state_d;
  sched_job_t       job_q, job_d;
  sched_job_t       sel_job;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               grant_en;

  // Grants only while idle; held off during reset so ready reads 0 asynchronously.
  assign grant_en = (state_q == IDLE) && !rst;

  dma_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (grant_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready_o     = gnt;
  assign busy_o          = (state_q != IDLE);
  assign dma_max_burst_o = 8'(MAX_BURST);
  assign desc_src_o      = ADDR_WIDTH'(job_q.src);
  assign desc_dst_o      = ADDR_WIDTH'(job_q.dst);
  assign desc_bytes_o    = BYTES_WIDTH'(job_q.bytes);
  assign desc_rd_mode_o  = job_q.rd_mode;
  assign desc_wr_mode_o  = job_q.wr_mode;

  // Pick out the granted requester's job fields.
  always_comb begin
    sel_job = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_job.src     = SCHED_ADDR_W'(req_src_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
        sel_job.dst     = SCHED_ADDR_W'(req_dst_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
        sel_job.bytes   = SCHED_BYTES_W'(req_bytes_i[i*BYTES_WIDTH +: BYTES_WIDTH]);
        sel_job.rd_mode = req_rd_mode_i[i];
        sel_job.wr_mode = req_wr_mode_i[i];
        sel_job.id      = ID_W'(i);
      end
    end
  end

  // Job sequencing: accept, program, go, wait for done/error/timeout, report.
  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    dma_go_o    = 1'b0;
    dma_abort_o = 1'b0;
    desc_en_o   = 1'b0;
    cmp_valid_o = 1'b0;
    cmp_id_o    = '0;
    cmp_error_o = 1'b0;
    timeout_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          job_d   = sel_job;
          err_d   = 1'b0;
          ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          // Nothing to move: report completion without touching the engine.
          state_d = (sel_job.bytes == '0) ? CMPL : LOAD;
        end
      end
      LOAD: begin
        desc_en_o = 1'b1;
        // A done level left over from the previous job must clear before go.
        if (!dma_done_i) begin
          state_d = GO;
        end
      end
      GO: begin
        desc_en_o = 1'b1;
        dma_go_o  = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        desc_en_o = 1'b1;
        if (dma_error_i) begin
          err_d   = 1'b1;
          state_d = CMPL;
        end else if (dma_done_i) begin
          state_d = CMPL;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          timeout_o = 1'b1;
          state_d   = ABORT;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        desc_en_o   = 1'b1;
        dma_abort_o = 1'b1;
        if (dma_done_i || dma_error_i) begin
          err_d   = 1'b1;
          state_d = CMPL;
        end
      end
      CMPL: begin
        cmp_valid_o = 1'b1;
        cmp_id_o    = IDX_W'(job_q.id);
        cmp_error_o = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, descriptor, pointer, error flag and timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      job_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_job_scheduler.sv
// tb/tb_dma_job_scheduler.sv - self-checking bench for dma_job_scheduler
module tb_dma_job_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i, req_ready_o, req_rd_mode_i, req_wr_mode_i;
  logic [N*AW-1:0] req_src_i, req_dst_i;
  logic [N*BW-1:0] req_bytes_i;
  logic            cmp_valid_o, cmp_error_o, dma_go_o, dma_abort_o;
  logic [1:0]      cmp_id_o;
  logic [7:0]      dma_max_burst_o;
  logic [AW-1:0]   desc_src_o, desc_dst_o;
  logic [BW-1:0]   desc_bytes_o;
  logic            desc_rd_mode_o, desc_wr_mode_o, desc_en_o;
  logic            dma_done_i, dma_error_i, busy_o, timeout_o;

  dma_job_scheduler #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .BYTES_WIDTH(BW), .TIMEOUT_CYC(TO), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src_i(req_src_i), .req_dst_i(req_dst_i), .req_bytes_i(req_bytes_i),
    .req_rd_mode_i(req_rd_mode_i), .req_wr_mode_i(req_wr_mode_i),
    .cmp_valid_o(cmp_valid_o), .cmp_id_o(cmp_id_o), .cmp_error_o(cmp_error_o),
    .dma_go_o(dma_go_o), .dma_abort_o(dma_abort_o), .dma_max_burst_o(dma_max_burst_o),
    .desc_src_o(desc_src_o), .desc_dst_o(desc_dst_o), .desc_bytes_o(desc_bytes_o),
    .desc_rd_mode_o(desc_rd_mode_o), .desc_wr_mode_o(desc_wr_mode_o), .desc_en_o(desc_en_o),
    .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Job-level model: a job is accepted, loaded until done is low, kicked once,
  // then waited on until done/error or TO waiting cycles pass, and finally reported.
  bit          m_busy = 0, m_cmpl_due = 0, m_go_due = 0, m_go_sent = 0, m_abort = 0, m_err = 0;
  int          m_id = 0, m_ptr = 0, m_wait_n = 0;
  logic [31:0] m_src = 0, m_dst = 0, m_bytes = 0;
  logic        m_rd = 0, m_wr = 0;

  logic [N-1:0] e_ready;
  logic         e_go, e_abort, e_en, e_busy, e_to, e_cmp, e_err, e_rd, e_wr;
  logic [1:0]   e_id;
  logic [31:0]  e_src, e_dst, e_bytes;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int pick;
    e_ready = '0; e_go = 0; e_abort = 0; e_en = 0; e_to = 0;
    e_cmp = 0; e_err = 0; e_id = 0; e_busy = 0;
    if (rst) begin
      m_busy = 0; m_cmpl_due = 0; m_ptr = 0;
      m_src = 0; m_dst = 0; m_bytes = 0; m_rd = 0; m_wr = 0; m_id = 0;
    end
    e_src = m_src; e_dst = m_dst; e_bytes = m_bytes; e_rd = m_rd; e_wr = m_wr;
    if (rst) return;
    e_busy = m_busy;
    if (!m_busy) begin
      pick = rr_pick(req_valid_i, m_ptr);
      if (pick >= 0) begin
        e_ready[pick] = 1'b1;
        m_id    = pick;
        m_src   = req_src_i[pick*AW +: AW];
        m_dst   = req_dst_i[pick*AW +: AW];
        m_bytes = req_bytes_i[pick*BW +: BW];
        m_rd    = req_rd_mode_i[pick];
        m_wr    = req_wr_mode_i[pick];
        m_ptr   = (pick + 1) % N;
        m_busy  = 1; m_go_due = 0; m_go_sent = 0; m_abort = 0; m_err = 0; m_wait_n = 0;
        m_cmpl_due = (m_bytes == 0);
      end
    end else if (m_cmpl_due) begin
      e_cmp = 1; e_id = 2'(m_id); e_err = m_err;
      m_busy = 0; m_cmpl_due = 0;
    end else begin
      e_en = 1;
      if (m_go_due) begin
        e_go = 1; m_go_due = 0; m_go_sent = 1; m_wait_n = 0;
      end else if (!m_go_sent) begin
        if (!dma_done_i) m_go_due = 1;
      end else if (m_abort) begin
        e_abort = 1;
        if (dma_done_i || dma_error_i) begin m_err = 1; m_cmpl_due = 1; end
      end else if (dma_error_i) begin
        m_err = 1; m_cmpl_due = 1;
      end else if (dma_done_i) begin
        m_cmpl_due = 1;
      end else if (m_wait_n + 1 == TO) begin
        e_to = 1; m_abort = 1;
      end else begin
        m_wait_n++;
      end
    end
  endtask

  int grant_q[$];
  int go_cnt  = 0;
  int cmp_cnt = 0;

  // Every cycle: advance the model and compare all outputs against it.
  always @(negedge clk) begin
    model_step();
    check("ready", req_ready_o, e_ready);
    check("ctrl", {dma_go_o, dma_abort_o, desc_en_o, busy_o, timeout_o},
                  {e_go, e_abort, e_en, e_busy, e_to});
    check("cmp", {cmp_valid_o, cmp_id_o, cmp_error_o}, {e_cmp, e_id, e_err});
    check("desc", {desc_src_o, desc_dst_o, desc_bytes_o, desc_rd_mode_o, desc_wr_mode_o},
                  {e_src, e_dst, e_bytes, e_rd, e_wr});
    check("burst", dma_max_burst_o, 8'd16);
    for (int i = 0; i < N; i++) if (req_ready_o[i]) grant_q.push_back(i);
    if (dma_go_o) go_cnt++;
    if (cmp_valid_o) cmp_cnt++;
  end

  // kind: 0 go, 1 completion, 2 timeout
  task automatic wait_ev(input int kind, input int max, output int at);
    at = -1;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if ((kind == 0 && dma_go_o === 1'b1) || (kind == 1 && cmp_valid_o === 1'b1) ||
          (kind == 2 && timeout_o === 1'b1)) begin
        at = cyc;
        break;
      end
    end
    check($sformatf("wait_event_%0d", kind), at >= 0, 1'b1);
  endtask

  task automatic set_req(input int i, input logic [31:0] s, input logic [31:0] d,
                         input logic [31:0] b, input logic rm, input logic wm);
    req_src_i[i*AW +: AW]   = s;
    req_dst_i[i*AW +: AW]   = d;
    req_bytes_i[i*BW +: BW] = b;
    req_rd_mode_i[i]        = rm;
    req_wr_mode_i[i]        = wm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int acc, g, c, t, snap;
    rst = 1; req_valid_i = '0; req_src_i = '0; req_dst_i = '0; req_bytes_i = '0;
    req_rd_mode_i = '0; req_wr_mode_i = '0; dma_done_i = 0; dma_error_i = 0;
    set_req(0, 32'h10, 32'h20, 32'd4, 0, 0);
    req_valid_i = 4'b1111;
    repeat (2) @(negedge clk);
    check("reset_ready", req_ready_o, 4'b0000);
    check("reset_outs", {busy_o, cmp_valid_o, dma_go_o, desc_en_o, desc_src_o}, 0);
    check("reset_burst", dma_max_burst_o, 8'd16);
    @(posedge clk); #1; req_valid_i = '0; set_req(0, 0, 0, 0, 0, 0); rst = 0;

    // Single job from requester 1
    @(posedge clk); #1;
    set_req(1, 32'h1000, 32'h2000, 32'd64, 0, 1);
    req_valid_i = 4'b0010;
    @(negedge clk); check("t1_ready", req_ready_o, 4'b0010); acc = cyc;
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(0, 10, g);
    check("t1_go_latency", g - acc, 2);
    check("t1_desc", {desc_src_o, desc_dst_o, desc_bytes_o}, {32'h1000, 32'h2000, 32'd64});
    repeat (20) @(posedge clk); #1; dma_done_i = 1;
    wait_ev(1, 10, c);
    check("t1_cmp_latency", c - g, 21);
    check("t1_cmp", {cmp_id_o, cmp_error_o}, {2'd1, 1'b0});
    @(posedge clk); #1; dma_done_i = 0;

    // Fairness from a fresh pointer
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 32'h8000 + i, 32'd16 + i, i[0], i[1]);
    grant_q.delete();
    req_valid_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ev(0, 10, g);
      repeat (5) @(posedge clk); #1; dma_done_i = 1;
      wait_ev(1, 10, c);
      @(posedge clk); #1; dma_done_i = 0;
    end
    req_valid_i = '0;
    check("fair_count", grant_q.size(), 5);
    begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      for (int j = 0; j < 5 && j < grant_q.size(); j++)
        check($sformatf("fair_grant_%0d", j), grant_q[j], exp_order[j]);
    end

    // Error wins over done in the same cycle
    @(posedge clk); #1;
    set_req(2, 32'hA000, 32'hB000, 32'd16, 1, 0);
    req_valid_i = 4'b0100;
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(0, 10, g);
    repeat (3) @(posedge clk); #1; dma_done_i = 1; dma_error_i = 1;
    wait_ev(1, 5, c);
    check("errprio_cmp", {cmp_id_o, cmp_error_o}, {2'd2, 1'b1});
    @(posedge clk); #1; dma_done_i = 0; dma_error_i = 0;

    // Timeout then abort
    @(posedge clk); #1;
    set_req(3, 32'hC000, 32'hD000, 32'd128, 0, 0);
    req_valid_i = 4'b1000;
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(0, 10, g);
    wait_ev(2, 120, t);
    check("timeout_wait_cycles", t - g, 100);
    repeat (3) begin
      @(negedge clk); check("abort_held", {dma_abort_o, cmp_valid_o}, 2'b10);
    end
    @(posedge clk); #1; dma_done_i = 1;
    wait_ev(1, 5, c);
    check("timeout_cmp", {cmp_id_o, cmp_error_o}, {2'd3, 1'b1});
    @(posedge clk); #1; dma_done_i = 0;

    // Zero-byte job completes without a go
    @(posedge clk); #1;
    set_req(0, 32'hE000, 32'hF000, 32'd0, 0, 0);
    req_valid_i = 4'b0001;
    @(negedge clk); acc = cyc; snap = go_cnt;
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(1, 5, c);
    check("zero_cmp_latency", c - acc, 1);
    check("zero_cmp", {cmp_id_o, cmp_error_o}, {2'd0, 1'b0});
    check("zero_no_go", go_cnt - snap, 0);

    // Stale done holds LOAD
    @(posedge clk); #1;
    set_req(1, 32'h3000, 32'h4000, 32'd8, 0, 0);
    req_valid_i = 4'b0010;
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(0, 10, g);
    repeat (2) @(posedge clk); #1; dma_done_i = 1;
    wait_ev(1, 5, c);
    @(posedge clk); #1;
    set_req(2, 32'h5000, 32'h6000, 32'd32, 1, 1);
    req_valid_i = 4'b0100;
    @(negedge clk); check("stale_ready", req_ready_o, 4'b0100); acc = cyc;
    @(posedge clk); #1; req_valid_i = '0;
    repeat (3) @(posedge clk); #1; dma_done_i = 0;
    wait_ev(0, 10, g);
    check("stale_go_latency", g - acc, 5);
    repeat (4) @(posedge clk); #1; dma_done_i = 1;
    wait_ev(1, 5, c);
    check("stale_cmp", {cmp_id_o, cmp_error_o}, {2'd2, 1'b0});
    @(posedge clk); #1; dma_done_i = 0;

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    set_req(0, 32'h7000, 32'h7100, 32'd100, 0, 0);
    req_valid_i = 4'b0001;
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(0, 10, g);
    repeat (3) @(posedge clk);
    #3; rst = 1;
    #1;
    check("rst_async_outs", {busy_o, desc_en_o, dma_go_o, dma_abort_o, cmp_valid_o, timeout_o,
                             req_ready_o, desc_src_o, desc_bytes_o}, 0);
    check("rst_async_burst", dma_max_burst_o, 8'd16);
    snap = cmp_cnt;
    set_req(3, 32'h9000, 32'h9100, 32'd4, 0, 0);
    req_valid_i = 4'b1001;
    @(posedge clk); #1; rst = 0;
    @(negedge clk); check("rst_ptr_grant", req_ready_o, 4'b0001);
    @(posedge clk); #1; req_valid_i = '0;
    wait_ev(0, 10, g);
    repeat (2) @(posedge clk); #1; dma_done_i = 1;
    wait_ev(1, 5, c);
    check("rst_next_cmp", {cmp_id_o, cmp_error_o}, {2'd0, 1'b0});
    @(posedge clk); #1; dma_done_i = 0;
    check("rst_no_stale_cmp", cmp_cnt - snap, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
